// File: rtl/spike_rate_decoder_if.sv
// Result bus of the spike-rate decoder: the valid/ready handshake together with
// the window result fields it qualifies.
`timescale 1ns/1ps
interface spike_rate_decoder_if #(
    parameter int NUM_NEURONS = 3,
    parameter int CNT_W       = 8
);
    localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

    logic                         out_valid;
    logic                         out_ready;
    logic [NUM_NEURONS*CNT_W-1:0] spike_counts;
    logic [IDX_W-1:0]             winner;
    logic                         no_spikes;
    logic                         saturated;

    modport master (
        output out_valid, spike_counts, winner, no_spikes, saturated,
        input  out_ready
    );

    modport slave (
        input  out_valid, spike_counts, winner, no_spikes, saturated,
        output out_ready
    );
endinterface

// File: rtl/spike_rate_decoder.sv
// Counts per-neuron spikes over a window of enable strobes and reports counts and winner.
// Optional: SPIKE_RATE_DECODER_AUTORESTART_EN re-arms the window on every handshake.
`timescale 1ns/1ps
module spike_rate_decoder #(
    parameter int NUM_NEURONS = 3,
    parameter int CNT_W       = 8,
    parameter int WIN_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [NUM_NEURONS-1:0] spike_in,
    input  logic [WIN_W-1:0]       window_len,
    input  logic                   start,
    output logic                   busy,
    spike_rate_decoder_if.master   res
);
    localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

    typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;

    state_t                             state_reg, state_next;
    logic                               load_win, count_step, finish_win, restart;
    logic [WIN_W:0]                     remaining_reg, len_ext, reload_val;
    logic [NUM_NEURONS-1:0][CNT_W-1:0]  cnt_reg, cnt_next;
    logic [NUM_NEURONS-1:0]             clip;
    logic                               sat_reg;
    logic [IDX_W-1:0]                   best_idx;
    logic [CNT_W-1:0]                   best_cnt;
    logic [NUM_NEURONS*CNT_W-1:0]       counts_out_reg;
    logic [IDX_W-1:0]                   winner_reg;
    logic                               no_spikes_reg, saturated_reg;

    // A zero length field encodes the full 2^WIN_W strobe window.
    assign len_ext = (window_len == '0) ? {1'b1, {WIN_W{1'b0}}} : {1'b0, window_len};

`ifdef SPIKE_RATE_DECODER_AUTORESTART_EN
    logic [WIN_W:0] reload_reg;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        reload_reg <= '0;
        else if (load_win) reload_reg <= len_ext;
    end
    assign reload_val = reload_reg;
`else
    assign reload_val = len_ext;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        load_win   = 1'b0;
        count_step = 1'b0;
        finish_win = 1'b0;
        restart    = 1'b0;
        case (state_reg)
            IDLE: if (start) begin
                load_win   = 1'b1;
                state_next = COUNT;
            end
            COUNT: if (enable) begin
                count_step = 1'b1;
                if (remaining_reg == (WIN_W+1)'(1)) begin
                    finish_win = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: if (res.out_ready) begin
`ifdef SPIKE_RATE_DECODER_AUTORESTART_EN
                restart    = 1'b1;
                state_next = COUNT;
`else
                state_next = IDLE;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    // Saturating increment candidates; clip flags a spike lost to a full counter.
    for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_cnt
        assign clip[gi]     = spike_in[gi] & (&cnt_reg[gi]);
        assign cnt_next[gi] = (spike_in[gi] && !(&cnt_reg[gi])) ? cnt_reg[gi] + CNT_W'(1)
                                                                : cnt_reg[gi];
    end

    // Strict greater-than keeps the lowest index on ties and index 0 when all are zero.
    always_comb begin
        best_idx = '0;
        best_cnt = cnt_next[0];
        for (int i = 1; i < NUM_NEURONS; i++) begin
            if (cnt_next[i] > best_cnt) begin
                best_cnt = cnt_next[i];
                best_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining_reg <= '0;
            cnt_reg       <= '0;
            sat_reg       <= 1'b0;
        end else if (load_win) begin
            remaining_reg <= len_ext;
            cnt_reg       <= '0;
            sat_reg       <= 1'b0;
        end else if (restart) begin
            remaining_reg <= reload_val;
            cnt_reg       <= '0;
            sat_reg       <= 1'b0;
        end else if (count_step) begin
            remaining_reg <= remaining_reg - (WIN_W+1)'(1);
            cnt_reg       <= cnt_next;
            sat_reg       <= sat_reg | (|clip);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counts_out_reg <= '0;
            winner_reg     <= '0;
            no_spikes_reg  <= 1'b0;
            saturated_reg  <= 1'b0;
        end else if (finish_win) begin
            counts_out_reg <= cnt_next;
            winner_reg     <= best_idx;
            no_spikes_reg  <= (best_cnt == '0);
            saturated_reg  <= sat_reg | (|clip);
        end
    end

    assign busy             = (state_reg != IDLE);
    assign res.out_valid    = (state_reg == HOLD);
    assign res.spike_counts = counts_out_reg;
    assign res.winner       = winner_reg;
    assign res.no_spikes    = no_spikes_reg;
    assign res.saturated    = saturated_reg;
endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder; the AUTORESTART macro selects the restart sequence.
`timescale 1ns/1ps
module tb_spike_rate_decoder;
    localparam int NN = 3;
    localparam int CW = 8;
    localparam int WW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [NN-1:0] spike_in;
    logic [WW-1:0] window_len;
    logic          start;
    logic          busy;
    int            n_vec = 0;
    int            n_err = 0;

    spike_rate_decoder_if #(.NUM_NEURONS(NN), .CNT_W(CW)) res_if ();

    spike_rate_decoder #(.NUM_NEURONS(NN), .CNT_W(CW), .WIN_W(WW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .spike_in   (spike_in),
        .window_len (window_len),
        .start      (start),
        .busy       (busy),
        .res        (res_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hold the given enable/spike for one rising edge, then settle 1 ns past it.
    task automatic step(input logic en, input logic [NN-1:0] spk);
        enable   = en;
        spike_in = spk;
        @(posedge clk);
        #1;
        enable   = 1'b0;
        spike_in = '0;
    endtask

    // Start cycle carries a live strobe with all spikes set; none must be counted.
    task automatic start_win(input logic [WW-1:0] len);
        window_len = len;
        start      = 1'b1;
        step(1'b1, '1);
        start      = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; spike_in = '0; window_len = '0; start = 1'b0;
        res_if.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(res_if.out_valid), 32'd0);
        check("rst_counts", 32'(res_if.spike_counts), 32'd0);
        check("rst_flags", {29'd0, res_if.no_spikes, res_if.saturated, 1'b0}, 32'd0);
        rst_n = 1'b1;

        // Reset mid-window discards the window
        start_win(8'd10);
        repeat (4) step(1'b1, 3'b111);
        check("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_counts", 32'(res_if.spike_counts), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (12) step(1'b1, 3'b111);
        check("mid_no_valid", 32'(res_if.out_valid), 32'd0);
        check("mid_idle", 32'(busy), 32'd0);

`ifdef SPIKE_RATE_DECODER_AUTORESTART_EN
        start_win(8'd2);
        step(1'b1, 3'b001);
        step(1'b1, 3'b001);
        check("ar1_valid", 32'(res_if.out_valid), 32'd1);
        check("ar1_counts", 32'(res_if.spike_counts), 32'h000002);
        res_if.out_ready = 1'b1;
        step(1'b1, 3'b100);
        res_if.out_ready = 1'b0;
        check("ar_hs_busy", 32'(busy), 32'd1);
        check("ar_hs_valid", 32'(res_if.out_valid), 32'd0);
        check("ar_hs_counts", 32'(res_if.spike_counts), 32'h000002);
        step(1'b1, 3'b010);
        check("ar_mid_busy", 32'(busy), 32'd1);
        check("ar_mid_valid", 32'(res_if.out_valid), 32'd0);
        step(1'b1, 3'b010);
        check("ar2_valid", 32'(res_if.out_valid), 32'd1);
        check("ar2_counts", 32'(res_if.spike_counts), 32'h000200);
        check("ar2_winner", 32'(res_if.winner), 32'd1);
        res_if.out_ready = 1'b1;
        step(1'b0, 3'b000);
        res_if.out_ready = 1'b0;
        check("ar2_busy", 32'(busy), 32'd1);
`else
        // Basic window
        start_win(8'd4);
        step(1'b1, 3'b001);
        step(1'b1, 3'b011);
        step(1'b1, 3'b001);
        check("basic_pre_valid", 32'(res_if.out_valid), 32'd0);
        step(1'b1, 3'b100);
        check("basic_valid", 32'(res_if.out_valid), 32'd1);
        check("basic_counts", 32'(res_if.spike_counts), 32'h010103);
        check("basic_winner", 32'(res_if.winner), 32'd0);
        check("basic_flags", {30'd0, res_if.no_spikes, res_if.saturated}, 32'd0);
        res_if.out_ready = 1'b1;
        step(1'b0, 3'b000);
        res_if.out_ready = 1'b0;
        check("basic_drop", 32'(res_if.out_valid), 32'd0);
        check("basic_keep", 32'(res_if.spike_counts), 32'h010103);
        check("basic_idle", 32'(busy), 32'd0);

        // Gapped enable with spikes held high, then backpressure
        start_win(8'd3);
        for (int s = 0; s < 3; s++) begin
            step(1'b1, 3'b010);
            if (s < 2) begin
                step(1'b0, 3'b010);
                step(1'b0, 3'b010);
            end
        end
        for (int c = 0; c < 5; c++) begin
            check("gap_stall_valid", 32'(res_if.out_valid), 32'd1);
            check("gap_stall_counts", 32'(res_if.spike_counts), 32'h000300);
            step(1'b1, 3'b111);
        end
        check("gap_winner", 32'(res_if.winner), 32'd1);
        res_if.out_ready = 1'b1;
        step(1'b0, 3'b000);
        res_if.out_ready = 1'b0;
        check("gap_drop", 32'(res_if.out_valid), 32'd0);

        // Tie, start during COUNT, start during handshake
        start_win(8'd2);
        step(1'b1, 3'b110);
        window_len = 8'd7;
        start = 1'b1;
        step(1'b0, 3'b000);
        start = 1'b0;
        check("tie_mid_valid", 32'(res_if.out_valid), 32'd0);
        step(1'b1, 3'b110);
        check("tie_valid", 32'(res_if.out_valid), 32'd1);
        check("tie_counts", 32'(res_if.spike_counts), 32'h020200);
        check("tie_winner", 32'(res_if.winner), 32'd1);
        res_if.out_ready = 1'b1;
        start = 1'b1;
        step(1'b0, 3'b000);
        start = 1'b0;
        res_if.out_ready = 1'b0;
        check("tie_hs_idle", 32'(busy), 32'd0);
        step(1'b0, 3'b000);
        check("tie_stay_idle", 32'(busy), 32'd0);

        // Zero spikes
        start_win(8'd1);
        step(1'b1, 3'b000);
        check("zero_valid", 32'(res_if.out_valid), 32'd1);
        check("zero_counts", 32'(res_if.spike_counts), 32'd0);
        check("zero_flag", 32'(res_if.no_spikes), 32'd1);
        check("zero_winner", 32'(res_if.winner), 32'd0);
        res_if.out_ready = 1'b1;
        step(1'b0, 3'b000);
        res_if.out_ready = 1'b0;

        // Full 256-strobe window saturates neuron 0
        start_win(8'd0);
        for (int s = 0; s < 255; s++) step(1'b1, 3'b001);
        check("sat_pre_valid", 32'(res_if.out_valid), 32'd0);
        step(1'b1, 3'b001);
        check("sat_valid", 32'(res_if.out_valid), 32'd1);
        check("sat_counts", 32'(res_if.spike_counts), 32'h0000ff);
        check("sat_flag", 32'(res_if.saturated), 32'd1);
        check("sat_no_spikes", 32'(res_if.no_spikes), 32'd0);
        res_if.out_ready = 1'b1;
        step(1'b0, 3'b000);
        res_if.out_ready = 1'b0;
        check("sat_drop", 32'(res_if.out_valid), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/spike_rate_decoder.md
Name: spike_rate_decoder

Overview:
- Output-side reader for the spiking neuron layer. Samples the layer's per-neuron spike outputs on the same enable strobe that advances the neurons.
- Counts spikes per neuron over a programmable window of enable strobes, then presents the counts and the winning neuron index through a valid/ready handshake.
- Sits between the layer's spike output and the host/IO logic.

Parameters:
- NUM_NEURONS, 3, number of spike inputs (one per neuron).
- CNT_W, 8, width of each per-neuron spike counter.
- WIN_W, 8, width of the window length field.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  neuron update strobe; spikes are sampled only when high.
- spike_in  input  NUM_NEURONS  spike outputs of the layer, bit i = neuron i.
- window_len  input  WIN_W  window length in enable strobes, latched on start; 0 means 2^WIN_W.
- start  input  1  begin a counting window; honoured only in IDLE.
- busy  output  1  high in COUNT and HOLD.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- spike_counts  output  NUM_NEURONS*CNT_W  counts, neuron i at bits [i*CNT_W +: CNT_W].
- winner  output  max(1,$clog2(NUM_NEURONS))  index of neuron with the highest count.
- no_spikes  output  1  all counts zero in the result.
- saturated  output  1  at least one counter clipped during the window.

Behaviour:
- Reset, asynchronous: FSM to IDLE. busy, out_valid, no_spikes, saturated, winner, spike_counts and the remaining-count register all go to 0. Reset mid-window discards the window; nothing partial is reported.
- FSM IDLE: busy=0, out_valid=0. start=1 latches window_len into remaining (0 loads 2^WIN_W), clears all counters and the saturated flag, and moves to COUNT the next cycle. Spikes in the start cycle are not counted.
- FSM COUNT: on each cycle with enable=1, every counter i whose spike_in[i]=1 increments by 1. Counters saturate at 2^CNT_W-1; a clipped increment sets saturated. Each such cycle decrements remaining. Cycles with enable=0 change nothing.
- Window end: when enable=1 and remaining==1, that strobe is counted, results are registered, and the FSM enters HOLD. out_valid is 1 on the next cycle, so latency is 1 cycle after the final strobe.
- Winner: computed from the final counts. The highest count wins; ties go to the lowest index. If all counts are 0: winner=0 and no_spikes=1.
- FSM HOLD: out_valid=1. spike_counts, winner, no_spikes and saturated are held stable. spike_in and enable are ignored, so spikes are dropped. start is ignored. When out_valid&&out_ready, go to IDLE next cycle; out_valid deasserts and the outputs keep their last values.
- start outside IDLE: ignored, with no effect on the current window.
- Simultaneous start and handshake in HOLD: start is ignored. A new start must come in IDLE.
- out_ready is ignored while out_valid=0.

Optional Feature:
- Macro: SPIKE_RATE_DECODER_AUTORESTART_EN.
- Defined: on the handshake cycle in HOLD, the FSM goes directly to COUNT instead of IDLE. It reloads remaining from the previously latched window length and clears counters and saturated; the result outputs stay at their last values. Strobes in the handshake cycle are not counted. busy stays 1 continuously. start has no effect except in IDLE, which is reachable only through reset.
- Undefined: handshake returns to IDLE as described above.

Test Plan:
- Reset mid-window: start with window_len=10, apply 4 strobes with spike_in=3'b111, then pulse rst_n low -> all outputs 0, FSM in IDLE, no out_valid afterwards without a new start.
- Basic window: window_len=4, 4 strobes with spike_in = 001, 011, 001, 100 -> one cycle after the 4th strobe out_valid=1, counts {n2=1, n1=1, n0=3}, winner=0, no_spikes=0, saturated=0.
- Gapped enable and backpressure: window_len=3, strobes separated by 2 idle cycles with spike_in=010 held high throughout, out_ready=0 for 5 cycles -> count n1=3 (not 9), outputs stable while stalled, out_valid drops the cycle after out_ready=1.
- Tie, zero and start-ignored: window_len=2 with spike_in=110 twice, then a start pulse during COUNT -> counts n1=n2=2, winner=1, window still ends after 2 strobes. Next window_len=1 with spike_in=000 -> no_spikes=1, winner=0.
- Saturation and wrap: window_len=0 (256 strobes) with spike_in=001 every strobe and CNT_W=8 -> n0=255, saturated=1, out_valid exactly one cycle after the 256th strobe.
- AUTORESTART_EN: window_len=2, handshake immediately on each result -> busy never drops, second result reflects only strobes after the handshake cycle.
